// File: rtl/edge_pulse_decoder.sv
// Receive-side decoder for an XOR edge-pulse stream. It filters glitches and stuck pulses,
// rebuilds the level, and reports edge/glitch strobes and a saturating edge count.
module edge_pulse_decoder #(
   parameter int MIN_WIDTH  = 2,
   parameter int MAX_WIDTH  = 8,
   parameter int HOLDOFF    = 4,
   parameter int CNT_W      = 8,
   parameter bit INIT_LEVEL = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pulse_in_i,
   input  logic             clr_i,
   output logic             level_out_o,
   output logic             edge_stb_o,
   output logic             glitch_stb_o,
   output logic             stuck_err_o,
   output logic [CNT_W-1:0] edge_count_o
);

   localparam int WW = $clog2(MAX_WIDTH + 1);
   localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

   localparam logic [WW-1:0]    MIN_W   = WW'(MIN_WIDTH);
   localparam logic [WW-1:0]    MAX_W   = WW'(MAX_WIDTH);
   localparam logic [HW-1:0]    HOLD_W  = HW'(HOLDOFF);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEASURE,
      S_HOLDOFF,
      S_STUCK
   } state_e;

   logic             sync1_q, sync2_q;
   logic             p_s;
   state_e           state_q, state_d;
   logic [WW-1:0]    width_q, width_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             level_q, level_d;
   logic             estb_q, estb_d;
   logic             gstb_q, gstb_d;
   logic             stuck_q, stuck_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             accept, reject, stuck_set;

   // pulse_in is asynchronous: two-flop synchronizer before any decision
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pulse_in_i;
         sync2_q <= sync1_q;
      end
   end

   assign p_s = sync2_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         width_q <= '0;
         hold_q  <= '0;
         level_q <= INIT_LEVEL;
         estb_q  <= 1'b0;
         gstb_q  <= 1'b0;
         stuck_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         width_q <= width_d;
         hold_q  <= hold_d;
         level_q <= level_d;
         estb_q  <= estb_d;
         gstb_q  <= gstb_d;
         stuck_q <= stuck_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      hold_d    = hold_q;
      accept    = 1'b0;
      reject    = 1'b0;
      stuck_set = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (p_s) begin
               state_d = S_MEASURE;
               width_d = WW'(1);
            end
         end
         S_MEASURE: begin
            if (p_s) begin
               // one more high sample would exceed the legal width
               if (width_q >= MAX_W) begin
                  state_d   = S_STUCK;
                  stuck_set = 1'b1;
               end else begin
                  width_d = width_q + 1'b1;
               end
            end else if (width_q >= MIN_W) begin
               accept  = 1'b1;
               state_d = S_HOLDOFF;
               hold_d  = HOLD_W;
            end else begin
               reject  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_HOLDOFF: begin
            // a pulse still high at expiry is swallowed until it falls
            if (hold_q == '0) begin
               if (!p_s) state_d = S_IDLE;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         S_STUCK: begin
            if (!p_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q ^ accept;
      estb_d  = accept;
      gstb_d  = reject;
      // a new stuck condition wins over a same-cycle clear
      stuck_d = stuck_set | (stuck_q & ~clr_i);
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (accept && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   assign level_out_o  = level_q;
   assign edge_stb_o   = estb_q;
   assign glitch_stb_o = gstb_q;
   assign stuck_err_o  = stuck_q;
   assign edge_count_o = count_q;

endmodule
